// File: rtl/owl_sfr_bank_if.sv
// Byte-wide SFR bus between the one-wire link controller (master) and the register bank (slave).
interface owl_sfr_bank_if;
  logic [5:0] sfr_addrs;
  logic [7:0] sfr_wdata;
  logic       sfr_wctrl;
  logic       sfr_rctrl;
  logic [7:0] sfr_rdata;

  modport master (
    output sfr_addrs, sfr_wdata, sfr_wctrl, sfr_rctrl,
    input  sfr_rdata
  );

  modport slave (
    input  sfr_addrs, sfr_wdata, sfr_wctrl, sfr_rctrl,
    output sfr_rdata
  );
endinterface

// File: rtl/owl_sfr_bank.sv
// Special-function register bank: chip ID, sticky link errors, control byte, key-protected
// trim registers behind a 0x5A/0xA5 unlock sequence with inactivity timeout, and scratch bytes.
module owl_sfr_bank #(
  parameter logic [7:0] CHIP_ID   = 8'hA5,
  parameter logic [7:0] TRIM_RST  = 8'h80,
  parameter int         TMO_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  owl_sfr_bank_if.slave sfr,
  input  logic          rxcrc_err,
  input  logic          rxcmd_err,
  input  logic          rxbit_err,
  input  logic          rxovf_err,
  output logic [7:0]    ctrl_out,
  output logic [95:0]   trim_out,
  output logic          unlocked
);

  typedef enum logic [1:0] {LOCKED, KEY1, UNLOCKED} key_state_t;

  key_state_t           state, state_nxt;
  logic [TMO_WIDTH-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [3:0]           err_q;
  logic [7:0]           ctrl_q;
  logic [7:0]           trim_q    [12];
  logic [7:0]           scratch_q [16];

  logic [5:0] addr;
  logic [7:0] wdata;
  logic       wr;
  logic       key_wr;
  logic       trim_hit;
  logic       trim_wr;
  logic       scratch_hit;
  logic [3:0] trim_idx;
  logic [3:0] err_in;
  logic [3:0] err_clr;
  logic       unused_rctrl;

  assign addr         = sfr.sfr_addrs;
  assign wdata        = sfr.sfr_wdata;
  assign wr           = sfr.sfr_wctrl;
  assign unused_rctrl = sfr.sfr_rctrl;

  assign key_wr      = wr && (addr == 6'h02);
  assign trim_hit    = (addr >= 6'h04) && (addr <= 6'h0F);
  assign trim_wr     = wr && trim_hit && (state == UNLOCKED);
  assign scratch_hit = (addr[5:4] == 2'b01);
  assign trim_idx    = addr[3:0] - 4'd4;
  assign err_in      = {rxovf_err, rxbit_err, rxcmd_err, rxcrc_err};
  assign err_clr     = (wr && (addr == 6'h01)) ? wdata[3:0] : 4'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOCKED;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // Timeout takes priority over a TRIM write in the same cycle; the write itself still lands.
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = '0;
    unique case (state)
      LOCKED: begin
        if (key_wr && (wdata == 8'h5A)) state_nxt = KEY1;
      end
      KEY1: begin
        if (wr) state_nxt = (key_wr && (wdata == 8'hA5)) ? UNLOCKED : LOCKED;
      end
      UNLOCKED: begin
        if ((&tmo_cnt) || key_wr) state_nxt = LOCKED;
        else if (!trim_wr) tmo_cnt_nxt = tmo_cnt + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
      end
      default: state_nxt = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      ctrl_q <= '0;
      for (int i = 0; i < 12; i++) trim_q[i] <= TRIM_RST;
      for (int i = 0; i < 16; i++) scratch_q[i] <= '0;
    end else begin
      err_q <= (err_q & ~err_clr) | err_in;
      if (wr && (addr == 6'h03)) ctrl_q <= wdata;
      if (trim_wr) trim_q[trim_idx] <= wdata;
      if (wr && scratch_hit) scratch_q[addr[3:0]] <= wdata;
    end
  end

  // Zero-latency read path; KEY and the unmapped upper half read as zero.
  always_comb begin
    sfr.sfr_rdata = 8'h00;
    if (addr == 6'h00)      sfr.sfr_rdata = CHIP_ID;
    else if (addr == 6'h01) sfr.sfr_rdata = {unlocked, 3'b000, err_q};
    else if (addr == 6'h03) sfr.sfr_rdata = ctrl_q;
    else if (trim_hit)      sfr.sfr_rdata = trim_q[trim_idx];
    else if (scratch_hit)   sfr.sfr_rdata = scratch_q[addr[3:0]];
  end

  assign ctrl_out = ctrl_q;
  assign unlocked = (state == UNLOCKED);

  for (genvar g = 0; g < 12; g++) begin : g_trim_out
    assign trim_out[g*8 +: 8] = trim_q[g];
  end

endmodule

// File: tb/tb_owl_sfr_bank.sv
// Directed walk-through of the register map and key sequence, then randomized traffic
// compared cycle by cycle against a reference model based on elapsed-cycle bookkeeping.
module tb_owl_sfr_bank;

  localparam int TMO_WIDTH  = 4;
  localparam int TMO_CYCLES = 1 << TMO_WIDTH;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  errs;
  logic [7:0]  ctrl_out;
  logic [95:0] trim_out;
  logic        unlocked;

  int n_assert = 0;
  int n_fail   = 0;

  owl_sfr_bank_if bus ();

  owl_sfr_bank #(
    .CHIP_ID   (8'hA5),
    .TRIM_RST  (8'h80),
    .TMO_WIDTH (TMO_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sfr       (bus),
    .rxcrc_err (errs[0]),
    .rxcmd_err (errs[1]),
    .rxbit_err (errs[2]),
    .rxovf_err (errs[3]),
    .ctrl_out  (ctrl_out),
    .trim_out  (trim_out),
    .unlocked  (unlocked)
  );

  always #5 clk = ~clk;

  // Reference model: protection is a mode plus the cycle of the last unlock/TRIM refresh.
  typedef enum {M_LOCKED, M_ARMED, M_OPEN} mode_t;

  mode_t      m_mode = M_LOCKED;
  logic [7:0] m_ctrl;
  logic [7:0] m_trim [12];
  logic [7:0] m_scr  [16];
  logic [3:0] m_err;
  int         cyc = 0;
  int         refresh_cyc = 0;
  int         ma;

  always @(posedge clk) begin
    cyc++;
    ma = int'(bus.sfr_addrs);
    if (rst) begin
      m_mode = M_LOCKED;
      m_ctrl = 8'h00;
      m_err  = 4'h0;
      foreach (m_trim[i]) m_trim[i] = 8'h80;
      foreach (m_scr[i]) m_scr[i] = 8'h00;
    end else begin
      if (bus.sfr_wctrl) begin
        if (ma == 3) m_ctrl = bus.sfr_wdata;
        if (ma >= 4 && ma <= 15 && m_mode == M_OPEN) m_trim[ma-4] = bus.sfr_wdata;
        if (ma >= 16 && ma <= 31) m_scr[ma-16] = bus.sfr_wdata;
        if (ma == 1) m_err = m_err & ~bus.sfr_wdata[3:0];
      end
      m_err = m_err | errs;
      case (m_mode)
        M_LOCKED: begin
          if (bus.sfr_wctrl && ma == 2 && bus.sfr_wdata == 8'h5A) m_mode = M_ARMED;
        end
        M_ARMED: begin
          if (bus.sfr_wctrl) begin
            if (ma == 2 && bus.sfr_wdata == 8'hA5) begin
              m_mode      = M_OPEN;
              refresh_cyc = cyc;
            end else begin
              m_mode = M_LOCKED;
            end
          end
        end
        M_OPEN: begin
          if (cyc - refresh_cyc == TMO_CYCLES) m_mode = M_LOCKED;
          else if (bus.sfr_wctrl && ma == 2) m_mode = M_LOCKED;
          else if (bus.sfr_wctrl && ma >= 4 && ma <= 15) refresh_cyc = cyc;
        end
        default: m_mode = M_LOCKED;
      endcase
    end
  end

  function automatic logic [7:0] model_read(input int a);
    if (a == 0)                 return 8'hA5;
    else if (a == 1)            return {m_mode == M_OPEN, 3'b000, m_err};
    else if (a == 3)            return m_ctrl;
    else if (a >= 4 && a <= 15) return m_trim[a-4];
    else if (a >= 16 && a <= 31) return m_scr[a-16];
    return 8'h00;
  endfunction

  function automatic logic [95:0] model_trim_out();
    logic [95:0] v;
    v = '0;
    for (int i = 0; i < 12; i++) v[i*8 +: 8] = m_trim[i];
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic w, input logic [5:0] a,
                               input logic [7:0] d, input logic [3:0] e);
    @(negedge clk);
    rst           = r;
    bus.sfr_wctrl = w;
    bus.sfr_rctrl = !w;
    bus.sfr_addrs = a;
    bus.sfr_wdata = d;
    errs          = e;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic writeReg(input logic [5:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 4'h0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 4'h0);
  endtask

  task automatic readCheck(input string tag, input logic [5:0] a, input logic [7:0] exp);
    applyStimulus(1'b0, 1'b0, a, 8'h00, 4'h0);
    checkOutput(tag, 96'(bus.sfr_rdata), 96'(exp));
  endtask

  int         r;
  logic       rw, rr, prev_5a;
  logic [5:0] ra;
  logic [7:0] rd;
  logic [3:0] re;

  initial begin
    applyStimulus(1'b1, 1'b0, 6'h00, 8'h00, 4'h0);
    applyStimulus(1'b1, 1'b0, 6'h00, 8'h00, 4'h0);

    $display("[TB] reset values");
    readCheck("rd_id", 6'h00, 8'hA5);
    checkOutput("trim_out_rst", trim_out, {12{8'h80}});
    checkOutput("unlocked_rst", 96'(unlocked), 96'(1'b0));
    checkOutput("ctrl_out_rst", 96'(ctrl_out), 96'(8'h00));
    readCheck("rd_status_rst", 6'h01, 8'h00);
    readCheck("rd_trim0_rst", 6'h04, 8'h80);
    readCheck("rd_hole_rst", 6'h20, 8'h00);

    $display("[TB] trim protection and unlock");
    writeReg(6'h05, 8'h33);
    readCheck("trim_locked", 6'h05, 8'h80);
    writeReg(6'h02, 8'h5A);
    writeReg(6'h02, 8'hA5);
    writeReg(6'h05, 8'h33);
    readCheck("trim_open", 6'h05, 8'h33);
    checkOutput("trim_out_open", 96'(trim_out[15:8]), 96'(8'h33));
    readCheck("status_open", 6'h01, 8'h80);
    writeReg(6'h02, 8'h00);
    readCheck("status_relock", 6'h01, 8'h00);

    $display("[TB] aborted key sequence");
    writeReg(6'h02, 8'h5A);
    writeReg(6'h10, 8'h77);
    writeReg(6'h02, 8'hA5);
    writeReg(6'h04, 8'h11);
    readCheck("scratch_in_key1", 6'h10, 8'h77);
    readCheck("trim_after_abort", 6'h04, 8'h80);
    checkOutput("unlocked_abort", 96'(unlocked), 96'(1'b0));

    $display("[TB] sticky errors and control");
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 4'b0100);
    readCheck("err_set", 6'h01, 8'h04);
    applyStimulus(1'b0, 1'b1, 6'h01, 8'h04, 4'b0100);
    readCheck("err_set_wins", 6'h01, 8'h04);
    writeReg(6'h01, 8'h04);
    readCheck("err_clear", 6'h01, 8'h00);
    writeReg(6'h03, 8'hC3);
    readCheck("ctrl_rd", 6'h03, 8'hC3);
    checkOutput("ctrl_out", 96'(ctrl_out), 96'(8'hC3));

    $display("[TB] inactivity timeout");
    writeReg(6'h02, 8'h5A);
    writeReg(6'h02, 8'hA5);
    for (int j = 1; j <= 17; j++) begin
      if (j == 16) writeReg(6'h07, 8'h3C);
      else idleCycle();
      if (j == 1)  checkOutput("tmo_start", 96'(unlocked), 96'(1'b1));
      if (j == 16) checkOutput("tmo_last_open", 96'(unlocked), 96'(1'b1));
      if (j == 17) checkOutput("tmo_fall", 96'(unlocked), 96'(1'b0));
    end
    readCheck("trim_at_timeout", 6'h07, 8'h3C);

    writeReg(6'h02, 8'h5A);
    writeReg(6'h02, 8'hA5);
    for (int j = 1; j <= 27; j++) begin
      if (j == 10) writeReg(6'h06, 8'h5C);
      else idleCycle();
      if (j == 17) checkOutput("refresh_hold", 96'(unlocked), 96'(1'b1));
      if (j == 26) checkOutput("refresh_last_open", 96'(unlocked), 96'(1'b1));
      if (j == 27) checkOutput("refresh_fall", 96'(unlocked), 96'(1'b0));
    end
    readCheck("trim_refresh_wr", 6'h06, 8'h5C);

    $display("[TB] reset during key sequence");
    writeReg(6'h02, 8'h5A);
    applyStimulus(1'b1, 1'b0, 6'h00, 8'h00, 4'h0);
    writeReg(6'h02, 8'hA5);
    idleCycle();
    checkOutput("rst_no_unlock", 96'(unlocked), 96'(1'b0));
    checkOutput("rst_ctrl_out", 96'(ctrl_out), 96'(8'h00));
    readCheck("rst_trim", 6'h06, 8'h80);
    readCheck("rst_scratch", 6'h10, 8'h00);

    $display("[TB] randomized traffic");
    prev_5a = 1'b0;
    for (int n = 0; n < 800; n++) begin
      rw = 1'b1;
      rr = 1'b0;
      rd = 8'($urandom);
      re = 4'h0;
      if ($urandom_range(0, 7) == 0) re = 4'($urandom);
      r = (prev_5a && $urandom_range(0, 3) != 0) ? 100 : int'($urandom_range(0, 15));
      case (r)
        100:     begin ra = 6'h02; rd = 8'hA5; end
        0, 1:    begin ra = 6'h02; rd = 8'h5A; end
        2:       ra = 6'h02;
        3, 4, 5: ra = 6'($urandom_range(4, 15));
        6:       ra = 6'h03;
        7:       ra = 6'h01;
        8, 9:    ra = 6'($urandom_range(16, 31));
        10:      ra = 6'($urandom_range(32, 63));
        default: begin rw = 1'b0; ra = 6'($urandom_range(0, 63)); end
      endcase
      if ($urandom_range(0, 149) == 0) rr = 1'b1;
      prev_5a = rw && !rr && (ra == 6'h02) && (rd == 8'h5A);
      applyStimulus(rr, rw, ra, rd, re);
      checkOutput("rnd_rdata", 96'(bus.sfr_rdata), 96'(model_read(int'(ra))));
      checkOutput("rnd_unlocked", 96'(unlocked), 96'(m_mode == M_OPEN));
      checkOutput("rnd_trim_out", trim_out, model_trim_out());
      checkOutput("rnd_ctrl_out", 96'(ctrl_out), 96'(m_ctrl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
